refill_arbiter: RTL and testbench
=================================

REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter NUM_MASTER, default 2: number of refill requesters (0 = ICache, 1 = DCache).
REQ-002 Parameter ADDR_W, default 32: AR address width.
REQ-003 Parameter DATA_W, default 64: R data width.
REQ-004 Parameter LEN_W, default 8: AR burst-length width.
REQ-005 Parameter ID_W, default 4: AXI ID width.
REQ-006 Port clk, input, 1: single clock for the block.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Ports m_ar_valid / m_ar_ready, input / output, NUM_MASTER each: per-master AR handshake.
REQ-009 Ports m_ar_addr / m_ar_len / m_ar_id, input, NUM_MASTER x ADDR_W / LEN_W / ID_W: per-master AR payload.
REQ-010 Ports m_r_valid / m_r_ready, output / input, NUM_MASTER each: per-master R handshake.
REQ-011 Ports m_r_data / m_r_last / m_r_id, output, DATA_W / 1 / ID_W: R payload, broadcast to all masters.
REQ-012 Ports s_ar_valid / s_ar_ready, output / input, 1 each: AR handshake toward the bus.
REQ-013 Ports s_ar_addr / s_ar_len / s_ar_id, output, ADDR_W / LEN_W / ID_W: AR payload toward the bus.
REQ-014 Ports s_r_valid / s_r_ready, input / output, 1 each: R handshake from the bus.
REQ-015 Ports s_r_data / s_r_last / s_r_id, input, DATA_W / 1 / ID_W: R payload from the bus.

Function
REQ-016 FSM states are IDLE, ADDR and DATA, with one outstanding burst at a time.
REQ-017 In IDLE with any m_ar_valid set, the arbiter latches grant using round-robin from rr_ptr, then moves to ADDR on the next edge; the AR issue latency is 1 cycle.
REQ-018 In ADDR:
- s_ar_valid = 1 and s_ar_* = m_ar_*[grant].
- m_ar_ready[grant] = s_ar_ready; every other m_ar_ready = 0.
- On the s_ar_valid & s_ar_ready handshake, the FSM moves to DATA.
REQ-019 In DATA:
- m_r_valid[grant] = s_r_valid and s_r_ready = m_r_ready[grant].
- Other masters' m_r_valid = 0.
- m_r_data, m_r_last and m_r_id pass through combinationally.
REQ-020 An R handshake with s_r_last = 1 moves the FSM to IDLE and sets rr_ptr = (grant + 1) mod NUM_MASTER.
REQ-021 A beat without last, or a stall on either side, holds the state and the grant unchanged.
REQ-022 A request arriving while the FSM is in ADDR or DATA is not granted until the FSM returns to IDLE; it waits at least 1 cycle after the last beat.
REQ-023 When several masters request simultaneously, the grant goes to the first requester at or after rr_ptr; no master waits more than NUM_MASTER-1 bursts.
REQ-024 A burst of s_ar_len = 0 (single beat) completes normally through ADDR, DATA and back to IDLE.
REQ-025 s_ar_valid, s_r_ready, all m_ar_ready and all m_r_valid are 0 in IDLE.
REQ-026 An m_ar_valid drop during ADDR is treated as an AXI violation; the arbiter still drives s_ar_valid = 1 for grant.

Reset
REQ-027 While rst = 0, and asynchronously on its assertion:
- state = IDLE, grant = 0, rr_ptr = 0.
- All handshake outputs = 0.
REQ-028 Reset asserted mid-burst abandons the burst with no completion signalled to the master; the bus side is reset together with this block.

Structure
REQ-029 The RefillArbState enum (IDLE/ADDR/DATA) and the ICACHE_MASTER / DCACHE_MASTER index constants are defined in the shared bundles package.
REQ-030 The round-robin priority pick is a sub-module rr_select (inputs: request vector, pointer; output: one-hot grant plus index).
REQ-031 The block is connected to the refill cache through ICacheAxi-style master/slave structs at the top level.

Verification
REQ-032 Single request, master 0, addr 0x8000_1000, len 3, 4 beats with s_ar_ready = 1 → s_ar_valid rises 1 cycle after the request; master 0 receives 4 beats; the FSM returns to IDLE; rr_ptr = 1.
REQ-033 Both masters request in the same cycle after reset → master 0 is served first; master 1's AR issues 1 cycle after master 0's last beat; rr_ptr ends at 0.
REQ-034 s_ar_ready held low for 5 cycles → s_ar_valid and the payload stay stable for 5 cycles; m_ar_ready[grant] pulses only in the handshake cycle.
REQ-035 m_r_ready[grant] = 0 on beat 2 of 4 → s_r_ready = 0 that cycle; no beat is lost or duplicated; m_r_valid of the other master stays 0 throughout.
REQ-036 rst pulled low during DATA beat 1 → all outputs are 0 immediately; after release, state = IDLE and a new master 1 request is granted with rr_ptr = 0.
REQ-037 Continuous requests from both masters for 8 bursts → grants alternate 0, 1, 0, 1, …; each burst has len 0 and completes in 3 cycles.

Source files
------------

// File: rtl/refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter.
package refill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } refill_arb_state_e;

    localparam int ICACHE_MASTER      = 0;
    localparam int DCACHE_MASTER      = 1;
    localparam int NUM_REFILL_MASTERS = DCACHE_MASTER + 1;

    // Bundle views of one refill AXI read channel at default widths.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } icache_axi_ar_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic        last;
        logic [3:0]  id;
    } icache_axi_r_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/refill_arbiter_rr_select.sv
// Round-robin pick: first requester at or after the pointer, wrapping.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int c;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/refill_arbiter.sv
// Arbitrates ICache/DCache refill bursts onto one AXI read port, one burst in flight.
//   state | meaning
//   IDLE  | no burst owned; pick next requester round-robin
//   ADDR  | presenting granted master's AR to the bus
//   DATA  | routing R beats to the granted master until last
module refill_arbiter
    import refill_arbiter_pkg::*;
#(
    parameter int NUM_MASTER = NUM_REFILL_MASTERS,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 8,
    parameter int ID_W       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTER-1:0]            m_ar_valid,
    output logic [NUM_MASTER-1:0]            m_ar_ready,
    input  logic [NUM_MASTER-1:0][ADDR_W-1:0] m_ar_addr,
    input  logic [NUM_MASTER-1:0][LEN_W-1:0] m_ar_len,
    input  logic [NUM_MASTER-1:0][ID_W-1:0]  m_ar_id,
    output logic [NUM_MASTER-1:0]            m_r_valid,
    input  logic [NUM_MASTER-1:0]            m_r_ready,
    output logic [DATA_W-1:0]                m_r_data,
    output logic                             m_r_last,
    output logic [ID_W-1:0]                  m_r_id,
    output logic                             s_ar_valid,
    input  logic                             s_ar_ready,
    output logic [ADDR_W-1:0]                s_ar_addr,
    output logic [LEN_W-1:0]                 s_ar_len,
    output logic [ID_W-1:0]                  s_ar_id,
    input  logic                             s_r_valid,
    output logic                             s_r_ready,
    input  logic [DATA_W-1:0]                s_r_data,
    input  logic                             s_r_last,
    input  logic [ID_W-1:0]                  s_r_id
);

    localparam int IDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    refill_arb_state_e       state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [NUM_MASTER-1:0]   grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NUM_MASTER-1:0]   sel_gnt;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_valid;

    rr_select #(
        .N     (NUM_MASTER),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i   (m_ar_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // R payload is broadcast; only the valid is steered to the owner.
    assign m_r_data = s_r_data;
    assign m_r_last = s_r_last;
    assign m_r_id   = s_r_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= IDX_W'(ICACHE_MASTER);
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        s_ar_valid = 1'b0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_id    = '0;
        s_r_ready  = 1'b0;
        m_ar_ready = '0;
        m_r_valid  = '0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d    = sel_idx;
                    grant_oh_d = sel_gnt;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                // Held for the granted master even if it drops its valid.
                s_ar_valid = 1'b1;
                s_ar_addr  = m_ar_addr[grant_q];
                s_ar_len   = m_ar_len[grant_q];
                s_ar_id    = m_ar_id[grant_q];
                m_ar_ready = grant_oh_q & {NUM_MASTER{s_ar_ready}};
                if (s_ar_ready) state_d = DATA;
            end
            DATA: begin
                m_r_valid = grant_oh_q & {NUM_MASTER{s_r_valid}};
                s_r_ready = m_r_ready[grant_q];
                if (s_r_valid && s_r_ready && s_r_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDX_W'(rr_next(int'(grant_q), NUM_MASTER));
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Randomised and directed bench for refill_arbiter against a transaction-level model.
module tb_refill_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int IW = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [N-1:0][AW-1:0]   m_ar_addr;
    logic [N-1:0][LW-1:0]   m_ar_len;
    logic [N-1:0][IW-1:0]   m_ar_id;
    logic [DW-1:0]          m_r_data, s_r_data;
    logic                   m_r_last, s_r_last;
    logic [IW-1:0]          m_r_id, s_r_id, s_ar_id;
    logic                   s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [AW-1:0]          s_ar_addr;
    logic [LW-1:0]          s_ar_len;

    refill_arbiter #(
        .NUM_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_id(m_r_id),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_id(s_r_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Master-side pending requests (held until accepted).
    bit            pend[N];
    logic [AW-1:0] p_addr[N];
    logic [LW-1:0] p_len[N];
    logic [IW-1:0] p_id[N];

    // Transaction model: who owns the bus, whether AR is done, beats left.
    int            owner = -1;
    bit            ar_done = 1'b0;
    int            rr = 0;
    int            beats_left = 0;
    logic [IW-1:0] burst_id = '0;
    bit            rv_hold = 1'b0;
    int            exp_beats[N];
    int            got_beats[N];

    int p_req = 0, p_ar = 100, p_rv = 100, p_mrr = 100, max_len = 3;
    bit gen_req = 1'b0;

    logic          snap_arv, snap_srr;
    logic [AW-1:0] snap_addr;
    logic [N-1:0]  snap_arr, snap_rv;
    int            dut_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (gen_req && !pend[i] && roll(p_req)) begin
                pend[i]   = 1'b1;
                p_addr[i] = $urandom;
                p_len[i]  = LW'($urandom_range(max_len, 0));
                p_id[i]   = IW'($urandom);
            end
            m_ar_valid[i] = pend[i];
            m_ar_addr[i]  = p_addr[i];
            m_ar_len[i]   = p_len[i];
            m_ar_id[i]    = p_id[i];
            m_r_ready[i]  = roll(p_mrr);
        end
        s_ar_ready = roll(p_ar);
        if (owner >= 0 && ar_done) begin
            if (!rv_hold) begin
                s_r_valid = roll(p_rv);
                s_r_data  = {$urandom, $urandom};
            end
            s_r_last = (beats_left == 1);
            s_r_id   = burst_id;
            rv_hold  = s_r_valid;
        end else begin
            s_r_valid = 1'b0;
            s_r_last  = 1'($urandom);
            s_r_data  = {$urandom, $urandom};
            s_r_id    = IW'($urandom);
        end
    endtask

    task automatic check_outs();
        bit aph, dph;
        int o;
        logic [N-1:0] e_arr, e_rv;
        aph = (owner >= 0) && !ar_done;
        dph = (owner >= 0) && ar_done;
        o   = (owner < 0) ? 0 : owner;
        for (int i = 0; i < N; i++) begin
            e_arr[i] = aph && (i == owner) && s_ar_ready;
            e_rv[i]  = dph && (i == owner) && s_r_valid;
        end
        chk("s_ar_valid", s_ar_valid, aph);
        chk("s_ar_addr", s_ar_addr, aph ? p_addr[o] : '0);
        chk("s_ar_len", s_ar_len, aph ? p_len[o] : '0);
        chk("s_ar_id", s_ar_id, aph ? p_id[o] : '0);
        chk("m_ar_ready", m_ar_ready, e_arr);
        chk("s_r_ready", s_r_ready, dph && m_r_ready[o]);
        chk("m_r_valid", m_r_valid, e_rv);
        chk("m_r_data", m_r_data, s_r_data);
        chk("m_r_last_id", {m_r_last, m_r_id}, {s_r_last, s_r_id});
        snap_arv  = s_ar_valid;
        snap_addr = s_ar_addr;
        snap_arr  = m_ar_ready;
        snap_rv   = m_r_valid;
        snap_srr  = s_r_ready;
        for (int i = 0; i < N; i++) begin
            if (m_r_valid[i] && m_r_ready[i]) got_beats[i]++;
            if (m_ar_ready[i]) dut_log.push_back(i);
        end
    endtask

    task automatic update();
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (owner < 0 && pend[(rr + k) % N]) begin
                    owner   = (rr + k) % N;
                    ar_done = 1'b0;
                end
            end
        end else if (!ar_done) begin
            if (s_ar_ready) begin
                ar_done    = 1'b1;
                pend[owner] = 1'b0;
                beats_left = int'(p_len[owner]) + 1;
                burst_id   = p_id[owner];
                exp_beats[owner] += beats_left;
            end
        end else if (s_r_valid && m_r_ready[owner]) begin
            rv_hold = 1'b0;
            beats_left--;
            if (beats_left == 0) begin
                rr    = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        gen();
        #1;
        check_outs();
        update();
        @(posedge clk);
    endtask

    task automatic model_reset();
        if (owner >= 0 && ar_done) exp_beats[owner] -= beats_left;
        owner = -1; ar_done = 1'b0; rr = 0; beats_left = 0; rv_hold = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        m_ar_valid = '0; s_r_valid = 1'b0; s_ar_ready = 1'b0; m_r_ready = '0;
    endtask

    task automatic req(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l);
        pend[m] = 1'b1; p_addr[m] = a; p_len[m] = l; p_id[m] = IW'(m + 3);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        m_ar_valid = '0; m_ar_addr = '0; m_ar_len = '0; m_ar_id = '0; m_r_ready = '0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_last = 1'b0; s_r_id = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_len[i] = '0; p_id[i] = '0;
            exp_beats[i] = 0; got_beats[i] = 0;
        end
        #3;
        chk("rst_s_ar_valid", s_ar_valid, 1'b0);
        chk("rst_m_ar_ready", m_ar_ready, 2'b00);
        chk("rst_m_r_valid", m_r_valid, 2'b00);
        chk("rst_s_r_ready", s_r_ready, 1'b0);
        @(negedge clk) rst = 1'b1;

        // Single 4-beat burst from master 0.
        req(0, 32'h8000_1000, 8'd3);
        step();
        chk("a_idle_arvalid", snap_arv, 1'b0);
        step();
        chk("a_ar_issue", snap_arv, 1'b1);
        chk("a_ar_addr", snap_addr, 32'h8000_1000);
        chk("a_ar_ready", snap_arr, 2'b01);
        repeat (4) step();
        step();
        chk("a_back_idle", snap_arv, 1'b0);
        chk("a_beats", got_beats[0], 4);

        // AR stall of 5 cycles.
        req(0, 32'h1234_5670, 8'd0);
        step();
        p_ar = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("e_hold_valid", snap_arv, 1'b1);
            chk("e_hold_addr", snap_addr, 32'h1234_5670);
            chk("e_no_ready", snap_arr, 2'b00);
        end
        p_ar = 100;
        step();
        chk("e_handshake", snap_arr, 2'b01);
        step();
        step();

        // Master backpressure on beat 2 of 4.
        req(0, 32'h0000_4000, 8'd3);
        k = got_beats[0];
        step(); step(); step();
        p_mrr = 0;
        step();
        chk("f_srr_low", snap_srr, 1'b0);
        chk("f_rv_owner_only", snap_rv, 2'b01);
        p_mrr = 100;
        repeat (4) step();
        chk("f_beats", got_beats[0] - k, 4);

        // Reset during the first data beat.
        req(0, 32'h0000_5000, 8'd3);
        p_mrr = 0;
        step(); step();
        @(negedge clk);
        gen();
        #1;
        check_outs();
        chk("c_beat1_valid", snap_rv, 2'b01);
        #1 rst = 1'b0;
        #1;
        chk("c_rst_arvalid", s_ar_valid, 1'b0);
        chk("c_rst_rvalid", m_r_valid, 2'b00);
        chk("c_rst_srready", s_r_ready, 1'b0);
        chk("c_rst_arready", m_ar_ready, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        p_mrr = 100;
        req(1, 32'h0000_2000, 8'd0);
        step(); step();
        chk("c_m1_addr", snap_addr, 32'h0000_2000);
        chk("c_m1_ready", snap_arr, 2'b10);
        step(); step();

        // Both masters at once with pointer back at 0.
        req(0, 32'hA000_0000, 8'd0);
        req(1, 32'hB000_0000, 8'd0);
        step(); step();
        chk("b_first_m0", snap_addr, 32'hA000_0000);
        step();
        step();
        chk("b_gap_idle", snap_arv, 1'b0);
        step();
        chk("b_second_m1", snap_addr, 32'hB000_0000);
        chk("b_m1_ready", snap_arr, 2'b10);
        step(); step();

        // Continuous single-beat requests: strict alternation, 3 cycles each.
        dut_log.delete();
        gen_req = 1'b1; p_req = 100; max_len = 0;
        repeat (24) step();
        chk("d_burst_count", dut_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk("d_alternate", dut_log[i], i % 2);

        // Random traffic.
        p_req = 30; p_ar = 60; p_rv = 70; p_mrr = 75; max_len = 3;
        repeat (3000) step();

        gen_req = 1'b0; p_ar = 100; p_rv = 100; p_mrr = 100;
        k = 0;
        while ((owner >= 0 || pend[0] || pend[1]) && k < 200) begin
            step();
            k++;
        end
        chk("drain_timeout", (owner >= 0 || pend[0] || pend[1]), 1'b0);
        for (int i = 0; i < N; i++)
            chk("beat_total", got_beats[i], exp_beats[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
